serial_to_parallel_idle_rx: RTL and testbench

Receive-side counterpart of the parallel-to-serial IDLE transmitter in the PCIe physical-layer lane. It samples the 1-bit serial lane on `clk32f` and hunts for the COM symbol at any bit offset to establish byte alignment. After `LOCK_COUNT` consecutive aligned COMs it declares the lane active. It then delivers every received byte in parallel and flags data bytes, as opposed to COM/IDLE, as valid to the byte-rate datapath.

---
 rtl/ptos_pkg.sv | 14 +
 rtl/serial_to_parallel_idle_rx_if.sv | 25 ++
 rtl/serial_to_parallel_idle_rx_com_detector.sv | 25 ++
 rtl/serial_to_parallel_idle_rx.sv | 138 +++++++++++++
 tb/tb_serial_to_parallel_idle_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ptos_pkg.sv
// Shared PCIe lane IDLE tx/rx definitions.
// State encoding and default symbol constants.
package ptos_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  localparam logic [7:0] PTOS_COM  = 8'hBC;
  localparam logic [7:0] PTOS_IDLE = 8'h7C;

endpackage

// File: rtl/serial_to_parallel_idle_rx_if.sv
// Serial lane in, parallel byte out bundle.
// master drives the lane bit, slave is the receiver.
interface serial_to_parallel_idle_rx_if;
  logic       in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_to_parallel_idle_rx_com_detector.sv
// Bit shift register and byte window compare.
// w is the byte ending with the current lane bit.
import ptos_pkg::*;

module com_detector #(
  parameter logic [7:0] COM_SYMBOL = PTOS_COM
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in,
  output logic [7:0] o_w,
  output logic       o_com_hit
);

  logic [7:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sr <= 8'h00;
    else          r_sr <= {r_sr[6:0], i_in};
  end

  assign o_w       = {r_sr[6:0], i_in};
  assign o_com_hit = (o_w == COM_SYMBOL);

endmodule

// File: rtl/serial_to_parallel_idle_rx.sv
// Serial IDLE receiver: COM hunt, alignment lock, byte out.
// RX_LOSS_DETECT_EN adds stuck-lane loss detection.
import ptos_pkg::*;

module serial_to_parallel_idle_rx #(
  parameter logic [7:0]  COM_SYMBOL  = PTOS_COM,
  parameter logic [7:0]  IDLE_SYMBOL = PTOS_IDLE,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input logic clk32f,
  input logic reset,
  serial_to_parallel_idle_rx_if.slave bus
);

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  logic [7:0] w_win;
  logic       w_com_hit;
  logic       w_bnd;
  logic       w_is_data;
  logic [3:0] w_com_nxt;

  rx_state_e  r_state;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_com_cnt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_strobe;
  logic       r_active;

  com_detector #(
    .COM_SYMBOL (COM_SYMBOL)
  ) u_det (
    .i_clk     (clk32f),
    .i_rst_n   (reset),
    .i_in      (bus.in),
    .o_w       (w_win),
    .o_com_hit (w_com_hit)
  );

  assign w_bnd     = (r_bit_cnt == 3'd7);
  assign w_com_nxt = r_com_cnt + 4'd1;
  assign w_is_data = (w_win != COM_SYMBOL) &&
                     (w_win != IDLE_SYMBOL);

`ifdef RX_LOSS_DETECT_EN
  logic [3:0] r_stuck;
  logic       w_stuck_byte;
  logic       w_loss;
  assign w_stuck_byte = (w_win == 8'h00) ||
                        (w_win == 8'hFF);
  assign w_loss = w_stuck_byte &&
                  ((r_stuck + 4'd1) == LC);

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset)
      r_stuck <= 4'd0;
    else if (r_state != LOCKED)
      r_stuck <= 4'd0;
    else if (w_bnd)
      r_stuck <= (w_stuck_byte && !w_loss) ?
                 r_stuck + 4'd1 : 4'd0;
  end
`else
  logic w_loss;
  assign w_loss = 1'b0;
`endif

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_state   <= HUNT;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      unique case (r_state)
        HUNT: begin
          r_valid  <= 1'b0;
          r_active <= 1'b0;
          if (w_com_hit) begin
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd1;
            if (LC == 4'd1) begin
              r_state  <= LOCKED;
              r_active <= 1'b1;
              r_strobe <= 1'b1;
              r_data   <= w_win;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd && w_com_hit) begin
            r_com_cnt <= w_com_nxt;
            // the locking COM is itself a strobed, non-valid byte
            if (w_com_nxt == LC) begin
              r_state  <= LOCKED;
              r_active <= 1'b1;
              r_strobe <= 1'b1;
              r_data   <= w_win;
              r_valid  <= 1'b0;
            end
          end else if (w_bnd) begin
            r_state   <= HUNT;
            r_com_cnt <= 4'd0;
          end
        end
        LOCKED: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd && w_loss) begin
            r_state   <= HUNT;
            r_active  <= 1'b0;
            r_valid   <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
          end else if (w_bnd) begin
            r_data   <= w_win;
            r_strobe <= 1'b1;
            r_valid  <= w_is_data;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign bus.data_out    = r_data;
  assign bus.valid_out   = r_valid;
  assign bus.byte_strobe = r_strobe;
  assign bus.active      = r_active;

endmodule

// File: tb/tb_serial_to_parallel_idle_rx.sv
// Directed bench for the serial IDLE receiver.
// Expectations follow RX_LOSS_DETECT_EN when defined.
module tb_serial_to_parallel_idle_rx;

  logic clk32f = 1'b0;
  logic reset  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  serial_to_parallel_idle_rx_if bus ();

  serial_to_parallel_idle_rx dut (
    .clk32f (clk32f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk32f = ~clk32f;

  task automatic send_bit(input logic b);
    @(negedge clk32f);
    bus.in = b;
    @(posedge clk32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic [7:0] smask);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      smask[i] = bus.byte_strobe;
    end
  endtask

  task automatic do_reset();
    @(negedge clk32f);
    reset  = 1'b0;
    bus.in = 1'b0;
    repeat (3) @(negedge clk32f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] o;
    bus.in = 1'b0;
    reset  = 1'b0;
    repeat (5) @(posedge clk32f);
    #1;
    o = {bus.data_out, bus.valid_out,
         bus.byte_strobe, bus.active};
    checks++;
    if (o !== 11'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", o);
    end
    @(negedge clk32f);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      send_bit(1'b0);
      o = {bus.data_out, bus.valid_out,
           bus.byte_strobe, bus.active};
      checks++;
      if (o !== 11'd0) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%h exp=0",
                 c, o);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] m;
    logic [7:0] com;
    com = 8'hBC;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (3) send_byte(com, m);
    for (int i = 7; i >= 1; i--) send_bit(com[i]);
    checks++;
    if (bus.active !== 1'b0) begin
      failures++;
      $display("FAIL lock_early got=%b exp=0",
               bus.active);
    end
    send_bit(com[0]);
    checks++;
    if ({bus.active, bus.byte_strobe, bus.valid_out}
        !== 3'b110) begin
      failures++;
      $display("FAIL lock_edge a/s/v got=%b%b%b exp=110",
               bus.active, bus.byte_strobe, bus.valid_out);
    end
  endtask

  task automatic test_data();
    logic [7:0] m;
    logic [7:0] bytes [4] = '{8'hA5, 8'h7C, 8'h3C, 8'hBC};
    logic       vexp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes[k], m);
      checks++;
      if (bus.data_out !== bytes[k] ||
          bus.valid_out !== vexp[k] ||
          bus.active !== 1'b1) begin
        failures++;
        $display("FAIL data k=%0d got=%h/%b/%b exp=%h/%b/1",
                 k, bus.data_out, bus.valid_out,
                 bus.active, bytes[k], vexp[k]);
      end
      checks++;
      if (m !== 8'h01) begin
        failures++;
        $display("FAIL strobe k=%0d got=%b exp=00000001",
                 k, m);
      end
    end
  endtask

  task automatic test_align_fail();
    logic [7:0] m;
    do_reset();
    repeat (3) send_byte(8'hBC, m);
    send_byte(8'h55, m);
    checks++;
    if ({bus.active, bus.valid_out} !== 2'b00 ||
        m !== 8'h00) begin
      failures++;
      $display("FAIL align_fail a/v=%b%b m=%b exp=00/0",
               bus.active, bus.valid_out, m);
    end
    repeat (5) send_bit(1'b0);
    repeat (3) send_byte(8'hBC, m);
    checks++;
    if (bus.active !== 1'b0) begin
      failures++;
      $display("FAIL relock_early got=%b exp=0",
               bus.active);
    end
    send_byte(8'hBC, m);
    checks++;
    if (bus.active !== 1'b1 || m !== 8'h01) begin
      failures++;
      $display("FAIL relock a=%b m=%b exp=1/00000001",
               bus.active, m);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    logic [10:0] o;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    reset = 1'b0;
    #1;
    o = {bus.data_out, bus.valid_out,
         bus.byte_strobe, bus.active};
    checks++;
    if (o !== 11'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", o);
    end
    bus.in = 1'b0;
    repeat (3) @(negedge clk32f);
    reset = 1'b1;
    repeat (3) send_byte(8'hBC, m);
    checks++;
    if (bus.active !== 1'b0) begin
      failures++;
      $display("FAIL mid_relock_early got=%b exp=0",
               bus.active);
    end
    send_byte(8'hBC, m);
    checks++;
    if (bus.active !== 1'b1) begin
      failures++;
      $display("FAIL mid_relock got=%b exp=1",
               bus.active);
    end
  endtask

  task automatic test_loss();
    logic [7:0] m;
    logic [1:0] e;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'h00, m);
`ifdef RX_LOSS_DETECT_EN
      e = (k == 3) ? 2'b00 : 2'b11;
`else
      e = 2'b11;
`endif
      checks++;
      if ({bus.active, bus.valid_out} !== e) begin
        failures++;
        $display("FAIL loss k=%0d a/v got=%b%b exp=%b",
                 k, bus.active, bus.valid_out, e);
      end
      if (e == 2'b11) begin
        checks++;
        if (bus.data_out !== 8'h00) begin
          failures++;
          $display("FAIL loss_data k=%0d got=%h exp=00",
                   k, bus.data_out);
        end
      end
    end
  endtask

  initial begin
    bus.in = 1'b0;
    test_reset();
    test_lock();
    test_data();
    test_align_fail();
    test_reset_mid();
    test_loss();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
